// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// APB3 initiator that turns a simple command/response handshake into APB
// SETUP/ACCESS transfers on a single completer. It waits on PREADY, returns the
// read data and the error status, and uses a watchdog to end any ACCESS phase
// whose completer never answers.
//
// Ports
//   PCLK, PRESETn           clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake; cmd_write, cmd_addr and
//                           cmd_wdata are captured when both are high
//   rsp_valid / rsp_ready   response handshake; rsp_rdata, rsp_err and
//                           rsp_timeout are held while rsp_valid is high
//   PSELx, PENABLE, PWRITE,
//   PADDR, PWDATA           APB request signals, all registered
//   PRDATA, PREADY, PSLVERR APB completer signals
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Watchdog counter is wide enough to hold TIMEOUT_CYCLES; one bit when the
  // watchdog is disabled so the declarations stay legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] WD_MAX = '1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           wd_cnt_reg, wd_cnt_next;
  logic                    cmd_ready_reg, cmd_ready_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic                    rsp_timeout_reg, rsp_timeout_next;
  logic                    psel_reg, psel_next;
  logic                    penable_reg, penable_next;
  logic                    pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;

  logic cmd_accept;
  logic wd_fire;

  // cmd_ready is registered and only high in IDLE, so this is the command
  // handshake.
  assign cmd_accept = cmd_valid & cmd_ready_reg;

  // The counter holds the number of ACCESS cycles already spent without
  // PREADY, so it equals TIMEOUT_CYCLES-1 during the last permitted cycle.
  // PREADY in that same cycle takes precedence.
  assign wd_fire = WD_EN && !PREADY && (wd_cnt_reg == WD_LAST);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= S_IDLE;
      wd_cnt_reg      <= '0;
      cmd_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      wd_cnt_reg      <= wd_cnt_next;
      cmd_ready_reg   <= cmd_ready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (cmd_accept) state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: if (PREADY || wd_fire) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Handshake/bus-phase flags follow the state being entered so they are
    // valid during that state's first cycle.
    cmd_ready_next   = (state_next == S_IDLE);
    psel_next        = (state_next == S_SETUP) || (state_next == S_ACCESS);
    penable_next     = (state_next == S_ACCESS);
    rsp_valid_next   = (state_next == S_RESP);

    // Request and response fields hold their values unless updated below.
    pwrite_next      = pwrite_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    wd_cnt_next      = wd_cnt_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (cmd_accept) begin
          pwrite_next = cmd_write;
          paddr_next  = cmd_addr;
          pwdata_next = cmd_wdata;
          wd_cnt_next = '0;
        end
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_rdata_next   = pwrite_reg ? '0 : PRDATA;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
        end else begin
          if (wd_fire) begin
            rsp_rdata_next   = '0;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b1;
          end
          // Saturate so a disabled watchdog never wraps.
          if (wd_cnt_reg != WD_MAX) wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign PSELx       = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PADDR       = paddr_reg;
  assign PWDATA      = pwdata_reg;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Drives APB3 transfers into the APB UART peripheral, or any single APB completer, from a simple command/response handshake interface. It provides the other end of the APB link: it generates the SETUP and ACCESS phases, waits on PREADY, and returns read data and error status. A watchdog terminates transfers whose completer never asserts PREADY. It is used as the bus initiator in the UART subsystem and as a synthesizable bus driver in integration benches.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and the command/response data fields
ADDR_WIDTH, 32, width of PADDR and cmd_addr
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles without PREADY before forced termination; 0 disables the watchdog

Ports:
PCLK  input  1  clock, rising edge
PRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a PCLK edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  output  1  PSLVERR seen or timeout
rsp_timeout  output  1  transfer terminated by the watchdog
PSELx  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  completer ready
PSLVERR  input  1  completer error, sampled only when PSELx & PENABLE & PREADY

Behaviour:
- Reset (PRESETn=0, async): state IDLE; all outputs 0, including PSELx, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_*. The watchdog counter is cleared. A transfer in progress is abandoned with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, drop cmd_ready, and go to SETUP.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0. Then go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1. PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
- ACCESS with PREADY=1: capture rsp_rdata (PRDATA if read, else 0) and rsp_err=PSLVERR. Set rsp_timeout=0. Go to RESP.
- ACCESS with PREADY=0: increment the watchdog counter.
- Watchdog: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES while PREADY=0, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to RESP. PREADY and the timeout firing in the same cycle: PREADY wins.
- RESP: PSELx=0, PENABLE=0, rsp_valid=1, response fields held stable. On rsp_ready, clear rsp_valid and go to IDLE. cmd_ready returns to 1 in the next cycle.
- rsp_ready with rsp_valid=0 is ignored. cmd_valid outside IDLE is ignored; the command is not queued.
- PADDR, PWRITE and PWDATA keep their last values in IDLE/RESP. They are don't-care on the bus while PSELx=0.
- Latency, zero-wait completer with rsp_ready held high:
  - cmd accepted at edge 0
  - SETUP during cycle 1
  - ACCESS during cycle 2
  - rsp_valid high during cycle 3
  - cmd_ready high during cycle 4
  - Throughput is 1 transfer per 4 cycles. Each PREADY wait state adds 1 cycle.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It is cleared on entry to SETUP. It never wraps.

Test Plan:
- Write, zero wait: cmd_write=1, addr=0x04, wdata=0xA5 -> SETUP then ACCESS with PADDR=0x04, PWDATA=0xA5, PWRITE=1; rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: PRDATA=0x5A, PREADY after 3 ACCESS cycles -> PADDR/PWRITE stable throughout; rsp_rdata=0x5A, rsp_valid in cycle 6.
- Slave error: PSLVERR=1 with PREADY on a read -> rsp_err=1, rsp_timeout=0; PSLVERR while PREADY=0 is ignored.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0 -> exactly 16 ACCESS cycles, then PSELx=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Also drive PREADY on the 16th cycle -> normal completion.
- Response backpressure and back-to-back: rsp_ready=0 for 5 cycles -> response held stable, cmd_ready=0, new cmd_valid ignored; after rsp_ready, the next command is accepted one cycle later.
- Reset mid-ACCESS: PRESETn low during ACCESS -> PSELx/PENABLE=0 immediately (async), no rsp_valid; after release, a new read completes normally.
